fp_align24: RTL and testbench

Exponent-alignment stage of the FP32 adder datapath, sitting directly upstream of the sign-magnitude-to-two's-complement pre-adder. Accepts two IEEE-754 single-precision operands, unpacks them, compares exponents, and right-shifts the smaller-exponent mantissa so both share the larger exponent. Emits per-operand sign plus 24-bit aligned magnitude (hidden bit included), the common exponent and a sticky flag. Two-stage pipeline with valid/ready flow control, one result per cycle.

---
 rtl/fp_align_pkg.sv | 38 +++
 rtl/fp_align24_rshift24.sv | 37 +++
 rtl/fp_align24.sv | 137 +++++++++++++
 tb/tb_fp_align24.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// Shared constants, unpacked-operand type and IEEE-754 single unpack helper for fp_align24.
// FP_ALIGN_DENORM_EN selects denormal support; otherwise exponent 0 flushes to zero.
package fp_align_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 24;
  localparam int unsigned FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } operand_t;

  // exp is the effective exponent used for alignment, not the raw field.
  function automatic operand_t unpack_op(input logic [31:0] x);
    operand_t r;
    r.sign = x[31];
    r.exp  = x[30:23];
    if (x[30:23] != '0) begin
      r.man = {1'b1, x[FRAC_W-1:0]};
    end else begin
`ifdef FP_ALIGN_DENORM_EN
      if (x[FRAC_W-1:0] != '0) begin
        r.man = {1'b0, x[FRAC_W-1:0]};
        r.exp = EXP_W'(1);
      end else begin
        r.man = '0;
      end
`else
      r.man = '0;
`endif
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_align24_rshift24.sv
// Combinational 24-bit logarithmic right shifter with sticky output.
// Shift amounts of 24 or more saturate to zero with sticky = OR of the whole input.
module rshift24
  import fp_align_pkg::*;
(
  input  logic [MAN_W-1:0] i_man,
  input  logic [EXP_W-1:0] i_amt,
  output logic [MAN_W-1:0] o_man,
  output logic             o_sticky
);

  logic [MAN_W-1:0] w_v;
  logic [MAN_W-1:0] w_mask;
  logic             w_st;

  always_comb begin
    w_v    = i_man;
    w_st   = 1'b0;
    w_mask = '0;
    if (i_amt >= EXP_W'(MAN_W)) begin
      w_v  = '0;
      w_st = |i_man;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (i_amt[k]) begin
          // Low 2^k bits fall off at this stage.
          w_mask = (MAN_W'(1) << (1 << k)) - MAN_W'(1);
          w_st   = w_st | (|(w_v & w_mask));
          w_v    = w_v >> (1 << k);
        end
      end
    end
    o_man    = w_v;
    o_sticky = w_st;
  end

endmodule

// File: rtl/fp_align24.sv
// FP32 exponent-alignment stage: unpack/compare (S1), shift smaller mantissa (S2).
// Optional denormal handling via FP_ALIGN_DENORM_EN (see fp_align_pkg).
module fp_align24
  import fp_align_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign1,
  output logic             sign2,
  output logic [MAN_W-1:0] man1,
  output logic [MAN_W-1:0] man2,
  output logic [EXP_W-1:0] exp_out,
  output logic             sticky,
  output logic             out_exc
);

  operand_t         w_op_a, w_op_b;
  logic             w_ge, w_exc;
  logic [EXP_W-1:0] w_diff;
  logic             w_s1_en, w_s2_en;

  logic             r_s1_valid;
  operand_t         r_s1_a, r_s1_b;
  logic             r_s1_ge, r_s1_exc;
  logic [EXP_W-1:0] r_s1_diff;

  logic [MAN_W-1:0] w_sh_in, w_sh_out;
  logic             w_sh_sticky;
  logic [MAN_W-1:0] w_man1, w_man2;
  logic [EXP_W-1:0] w_exp;
  logic             w_sticky;

  logic             r_out_valid;
  logic             r_sign1, r_sign2;
  logic [MAN_W-1:0] r_man1, r_man2;
  logic [EXP_W-1:0] r_exp;
  logic             r_sticky, r_exc;

  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  always_comb begin
    w_op_a = unpack_op(a);
    w_op_b = unpack_op(b);
    w_ge   = (w_op_a.exp >= w_op_b.exp);
    w_diff = w_ge ? (w_op_a.exp - w_op_b.exp) : (w_op_b.exp - w_op_a.exp);
    w_exc  = (a[30:23] == EXP_MAX) || (b[30:23] == EXP_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_ge    <= 1'b0;
      r_s1_exc   <= 1'b0;
      r_s1_diff  <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a    <= w_op_a;
        r_s1_b    <= w_op_b;
        r_s1_ge   <= w_ge;
        r_s1_exc  <= w_exc;
        r_s1_diff <= w_diff;
      end
    end
  end

  assign w_sh_in = r_s1_ge ? r_s1_b.man : r_s1_a.man;

  rshift24 u_rshift (
    .i_man    (w_sh_in),
    .i_amt    (r_s1_diff),
    .o_man    (w_sh_out),
    .o_sticky (w_sh_sticky)
  );

  // Exceptional operands bypass alignment entirely.
  always_comb begin
    w_man1   = r_s1_a.man;
    w_man2   = r_s1_b.man;
    w_exp    = EXP_MAX;
    w_sticky = 1'b0;
    if (!r_s1_exc) begin
      if (r_s1_ge) begin
        w_man2 = w_sh_out;
        w_exp  = r_s1_a.exp;
      end else begin
        w_man1 = w_sh_out;
        w_exp  = r_s1_b.exp;
      end
      w_sticky = w_sh_sticky;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sign1     <= 1'b0;
      r_sign2     <= 1'b0;
      r_man1      <= '0;
      r_man2      <= '0;
      r_exp       <= '0;
      r_sticky    <= 1'b0;
      r_exc       <= 1'b0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sign1  <= r_s1_a.sign;
        r_sign2  <= r_s1_b.sign;
        r_man1   <= w_man1;
        r_man2   <= w_man2;
        r_exp    <= w_exp;
        r_sticky <= w_sticky;
        r_exc    <= r_s1_exc;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sign1     = r_sign1;
  assign sign2     = r_sign2;
  assign man1      = r_man1;
  assign man2      = r_man2;
  assign exp_out   = r_exp;
  assign sticky    = r_sticky;
  assign out_exc   = r_exc;

endmodule

// File: tb/tb_fp_align24.sv
// Directed self-checking bench for fp_align24 with hand-computed expectations.
module tb_fp_align24;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic        sign1, sign2;
  logic [23:0] man1, man2;
  logic [7:0]  exp_out;
  logic        sticky;
  logic        out_exc;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fp_align24 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign1     (sign1),
    .sign2     (sign2),
    .man1      (man1),
    .man2      (man2),
    .exp_out   (exp_out),
    .sticky    (sticky),
    .out_exc   (out_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic s1, input logic s2,
                            input logic [23:0] m1, input logic [23:0] m2,
                            input logic [7:0] e, input logic st, input logic ex);
    chk({tag, ".valid"},  32'(out_valid), 32'd1);
    chk({tag, ".sign1"},  32'(sign1),     32'(s1));
    chk({tag, ".sign2"},  32'(sign2),     32'(s2));
    chk({tag, ".man1"},   32'(man1),      32'(m1));
    chk({tag, ".man2"},   32'(man2),      32'(m2));
    chk({tag, ".exp"},    32'(exp_out),   32'(e));
    chk({tag, ".sticky"}, 32'(sticky),    32'(st));
    chk({tag, ".exc"},    32'(out_exc),   32'(ex));
  endtask

  // Accept one pair, confirm S2 still empty, then check the result one edge later.
  task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic s1, input logic s2, input logic [23:0] m1,
                         input logic [23:0] m2, input logic [7:0] e, input logic st,
                         input logic ex);
    a = va;
    b = vb;
    in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, ".lat"}, 32'(out_valid), 32'd0);
    step();
    expect_out(tag, s1, s2, m1, m2, e, st, ex);
    step();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    step();
    step();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.man1",      32'(man1),      32'd0);
    chk("rst.exp",       32'(exp_out),   32'd0);
    rst = 1'b0;
    step();

    run_vec("v1_1p0_2p0",  32'h3F800000, 32'h40000000, 0, 0, 24'h400000, 24'h800000, 8'h80, 0, 0);
    run_vec("v2_neg",      32'hC0400000, 32'h3F000000, 1, 0, 24'hC00000, 24'h200000, 8'h80, 0, 0);
    run_vec("v3_diff24",   32'h4B800000, 32'h3F800001, 0, 0, 24'h800000, 24'h000000, 8'h97, 1, 0);
    run_vec("v4_diff23",   32'h4B000000, 32'h3F800000, 0, 0, 24'h800000, 24'h000001, 8'h96, 0, 0);
    run_vec("v5_equal",    32'h40400000, 32'hC0000000, 0, 1, 24'hC00000, 24'h800000, 8'h80, 0, 0);
    run_vec("v6_stky1",    32'h40000000, 32'h3F800001, 0, 0, 24'h800000, 24'h400000, 8'h80, 1, 0);
    run_vec("v7_zero",     32'h00000000, 32'h3F800000, 0, 0, 24'h000000, 24'h800000, 8'h7F, 0, 0);
`ifdef FP_ALIGN_DENORM_EN
    run_vec("v8_denorm",   32'h00800000, 32'h00000001, 0, 0, 24'h800000, 24'h000001, 8'h01, 0, 0);
`else
    run_vec("v8_denorm",   32'h00800000, 32'h00000001, 0, 0, 24'h800000, 24'h000000, 8'h01, 0, 0);
`endif

    // Back-pressure: three pairs offered while downstream stalls.
    out_ready = 1'b0;
    b = 32'h0;
    a = 32'h3F800000;
    in_valid = 1'b1;
    step();
    a = 32'h40400000;
    step();
    a = 32'h40A00000;
    chk("bp.in_ready_low", 32'(in_ready), 32'd0);
    chk("bp.hold_valid",   32'(out_valid), 32'd1);
    chk("bp.hold_man1",    32'(man1), 32'h800000);
    step();
    chk("bp.frozen_man1",  32'(man1), 32'h800000);
    chk("bp.frozen_exp",   32'(exp_out), 32'h7F);
    chk("bp.still_stall",  32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp.ready_comb",   32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp.r2_man1",      32'(man1), 32'hC00000);
    chk("bp.r2_exp",       32'(exp_out), 32'h80);
    step();
    chk("bp.r3_valid",     32'(out_valid), 32'd1);
    chk("bp.r3_man1",      32'(man1), 32'hA00000);
    chk("bp.r3_exp",       32'(exp_out), 32'h81);
    step();
    chk("bp.drained",      32'(out_valid), 32'd0);

    // Reset with both stages occupied.
    out_ready = 1'b0;
    a = 32'h3F800000;
    b = 32'h3F800000;
    in_valid = 1'b1;
    step();
    step();
    chk("rf.full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rf.out_valid", 32'(out_valid), 32'd0);
    chk("rf.in_ready",  32'(in_ready),  32'd1);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rf.no_out1", 32'(out_valid), 32'd0);
    step();
    chk("rf.no_out2", 32'(out_valid), 32'd0);
    run_vec("v9_inf", 32'h7F800000, 32'h3F800000, 0, 0, 24'h800000, 24'h800000, 8'hFF, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
